// File: rtl/rr_otf_convert_if.sv
// Digit-in / word-out handshake bundle for the radix-RADIX on-the-fly converter.
interface rr_otf_convert_if #(
   parameter int RADIX = 4,
   parameter int WIDTH = 7
);
   localparam int K = $clog2(RADIX);
   localparam int D = K + 1;
   localparam int L = WIDTH * K + 1;

   logic         in_valid;
   logic         in_ready;
   logic [D-1:0] in_digit;
   logic         out_valid;
   logic         out_ready;
   logic [L-1:0] out_value;
   logic         digit_err;

   modport master (
      output in_valid, in_digit, out_ready,
      input  in_ready, out_valid, out_value, digit_err
   );

   modport slave (
      input  in_valid, in_digit, out_ready,
      output in_ready, out_valid, out_value, digit_err
   );
endinterface

// File: rtl/rr_otf_convert.sv
// MSD-first signed-digit to two's-complement on-the-fly converter (Q/QM pair).
// Optional illegal-digit flag enabled by RR_OTF_DIGIT_CHECK_EN.
module rr_otf_convert #(
   parameter int RADIX = 4,
   parameter int WIDTH = 7
) (
   input  logic              clock,
   input  logic              reset,
   rr_otf_convert_if.slave   bus
);
   localparam int K  = $clog2(RADIX);
   localparam int D  = K + 1;
   localparam int L  = WIDTH * K + 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [L-1:0]  C_R    = L'(RADIX);
   localparam logic [L-1:0]  C_RM1  = L'(RADIX - 1);
   localparam logic [L-1:0]  C_ONE  = L'(1);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      ACCUM,
      HOLD
   } state_t;

   state_t        r_state;
   logic [L-1:0]  r_q;
   logic [L-1:0]  r_qm;
   logic [CW-1:0] r_cnt;
   logic          r_out_valid;
   logic [L-1:0]  r_out_value;

   logic                 w_hold;
   logic                 w_in_ready;
   logic                 w_acc;
   logic [L-1:0]         w_bq;
   logic [L-1:0]         w_bqm;
   logic [CW-1:0]        w_bcnt;
   logic                 w_last;
   logic signed [L-1:0]  w_dx;
   logic                 w_neg;
   logic                 w_pos;
   logic [L-1:0]         w_q_sh;
   logic [L-1:0]         w_qm_sh;
   logic [L-1:0]         w_nq;
   logic [L-1:0]         w_nqm;

   assign w_hold     = (r_state == HOLD);
   assign w_in_ready = !w_hold || bus.out_ready;
   assign w_acc      = bus.in_valid && w_in_ready;

   // A digit taken while leaving HOLD is digit 0 of a fresh word.
   assign w_bq   = w_hold ? '0 : r_q;
   assign w_bqm  = w_hold ? '1 : r_qm;
   assign w_bcnt = w_hold ? '0 : r_cnt;
   assign w_last = (w_bcnt == C_LAST);

   assign w_dx    = L'($signed(bus.in_digit));
   assign w_neg   = bus.in_digit[D-1];
   assign w_pos   = !w_neg && (|bus.in_digit);
   assign w_q_sh  = w_bq << K;
   assign w_qm_sh = w_bqm << K;

   assign w_nq  = w_neg ? (w_qm_sh + C_R + w_dx)
                        : (w_q_sh + w_dx);
   assign w_nqm = w_pos ? (w_q_sh + w_dx - C_ONE)
                        : (w_qm_sh + C_RM1 + w_dx);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ACCUM;
         r_q         <= '0;
         r_qm        <= '1;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_value <= '0;
      end else if (w_acc) begin
         r_q  <= w_nq;
         r_qm <= w_nqm;
         if (w_last) begin
            r_cnt       <= '0;
            r_out_value <= w_nq;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
         end else begin
            r_cnt       <= w_bcnt + CW'(1);
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
         end
      end else if (w_hold && bus.out_ready) begin
         r_q         <= '0;
         r_qm        <= '1;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_state     <= ACCUM;
      end
   end

`ifdef RR_OTF_DIGIT_CHECK_EN
   localparam logic [D-1:0] C_BAD = {1'b1, {K{1'b0}}};

   logic r_err;

   // Sticky until reset; the -RADIX code is still run through the datapath.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_acc && (bus.in_digit == C_BAD)) begin
         r_err <= 1'b1;
      end
   end

   assign bus.digit_err = r_err;
`else
   assign bus.digit_err = 1'b0;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_value = r_out_value;
endmodule

// File: tb/tb_rr_otf_convert.sv
// Directed-vector bench for rr_otf_convert, RADIX=4 WIDTH=3 (7-bit result).
// Expected values hand-computed from the digit sums.
module tb_rr_otf_convert;
   localparam int RADIX = 4;
   localparam int WIDTH = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;
   logic rdy_seen;

   rr_otf_convert_if #(.RADIX(RADIX), .WIDTH(WIDTH)) bus ();

   rr_otf_convert #(.RADIX(RADIX), .WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Hold inputs across one rising edge; rdy_seen is in_ready before it.
   task automatic step(input int v, input int d, input int ordy);
      bus.in_valid  = v[0];
      bus.in_digit  = 3'(d);
      bus.out_ready = ordy[0];
      #1;
      rdy_seen = bus.in_ready;
      @(posedge clock);
      #1;
   endtask

   function automatic int val();
      return int'($signed(bus.out_value));
   endfunction

   task automatic word(input string tag, input int d0, input int d1,
                       input int d2, input int exp);
      step(1, d0, 1);
      chk({tag, "_rdy0"}, int'(rdy_seen), 1);
      chk({tag, "_v0"}, int'(bus.out_valid), 0);
      step(1, d1, 1);
      chk({tag, "_rdy1"}, int'(rdy_seen), 1);
      chk({tag, "_v1"}, int'(bus.out_valid), 0);
      step(1, d2, 1);
      chk({tag, "_rdy2"}, int'(rdy_seen), 1);
      chk({tag, "_v2"}, int'(bus.out_valid), 1);
      chk({tag, "_val"}, val(), exp);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_digit  = '0;
      bus.out_ready = 1'b1;

      reset = 1'b1;
      step(1, 3, 1);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_value", val(), 0);
      chk("rst_err", int'(bus.digit_err), 0);
      chk("rst_rdy", int'(bus.in_ready), 1);
      reset = 1'b0;

      // Back-to-back words, no idle cycles.
      word("w11", 1, -2, 3, 11);
      word("w63", 3, 3, 3, 63);
      word("wm63", -3, -3, -3, -63);
      chk("wm63_bits", int'(bus.out_value), 7'b1000001);
      word("wm3", 0, -1, 1, -3);
      word("w11b", 1, -2, 3, 11);
      word("wm16", -1, 0, 0, -16);

      // Backpressure on a completed 11.
      word("bp", 1, -2, 3, 11);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0);
         chk("bp_rdy", int'(rdy_seen), 0);
         chk("bp_valid", int'(bus.out_valid), 1);
         chk("bp_val", val(), 11);
      end
      step(1, 2, 1);
      chk("bp_release_rdy", int'(rdy_seen), 1);
      chk("bp_release_v", int'(bus.out_valid), 0);
      step(1, 0, 1);
      step(1, 0, 1);
      chk("bp_next_v", int'(bus.out_valid), 1);
      chk("bp_next_val", val(), 32);

      // Transfer with no new digit, then idle.
      step(0, 3, 1);
      chk("drain_v", int'(bus.out_valid), 0);
      step(0, 3, 1);
      chk("idle_v", int'(bus.out_valid), 0);
      chk("idle_rdy", int'(bus.in_ready), 1);

      // Reset mid-word, then 1,1,1 with a gap.
      step(1, 3, 1);
      step(1, 3, 1);
      reset = 1'b1;
      step(1, 3, 1);
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      chk("mid_rst_value", val(), 0);
      chk("mid_rst_err", int'(bus.digit_err), 0);
      chk("mid_rst_rdy", int'(bus.in_ready), 1);
      reset = 1'b0;
      step(1, 1, 1);
      step(0, -3, 1);
      chk("gap_v", int'(bus.out_valid), 0);
      step(1, 1, 1);
      step(1, 1, 1);
      chk("w21_v", int'(bus.out_valid), 1);
      chk("w21_val", val(), 21);

      // -4 as digit 1.
      step(1, 0, 1);
      chk("err_pre", int'(bus.digit_err), 0);
      step(1, -4, 1);
`ifdef RR_OTF_DIGIT_CHECK_EN
      chk("err_set", int'(bus.digit_err), 1);
`else
      chk("err_set", int'(bus.digit_err), 0);
`endif
      step(1, 0, 1);
      chk("err_word_v", int'(bus.out_valid), 1);
      word("err_after", 1, 1, 1, 21);
`ifdef RR_OTF_DIGIT_CHECK_EN
      chk("err_sticky", int'(bus.digit_err), 1);
`else
      chk("err_sticky", int'(bus.digit_err), 0);
`endif
      reset = 1'b1;
      step(0, 0, 1);
      chk("err_clr", int'(bus.digit_err), 0);
      chk("err_clr_valid", int'(bus.out_valid), 0);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
